instr_fetch_stage: RTL

//  Instruction-fetch stage plus IF/ID pipeline register for the 16-bit CPU datapath.

---
 rtl/cpu_defs_pkg.sv | 19 +
 rtl/instr_fetch_stage_if_id_reg.sv | 39 +++
 rtl/instr_fetch_stage.sv | 135 +++++++++++++
 3 files changed

// File: rtl/cpu_defs_pkg.sv
// Shared CPU datapath definitions: instruction field positions, bubble word,
// PC increment and fetch-stage state encodings.
package cpu_defs;

   localparam int OPCODE_MSB = 15;
   localparam int OPCODE_LSB = 12;
   localparam int FUNC_MSB   = 3;
   localparam int FUNC_LSB   = 0;

   localparam logic [15:0] NOP_INSTR = 16'h0000;
   localparam logic [15:0] PC_INC    = 16'd2;

   typedef enum logic [1:0] {
      BOOT = 2'd0,
      RUN  = 2'd1,
      TRAP = 2'd2
   } fetch_state_e;

endpackage

// File: rtl/instr_fetch_stage_if_id_reg.sv
// IF/ID pipeline register with hold and bubble-insert controls.
// Priority on an edge: reset > hold > bubble > load.
module if_id_reg #(
   parameter int              INSTR_W   = 16,
   parameter int              PC_W      = 16,
   parameter logic [INSTR_W-1:0] NOP_INSTR = '0
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               hold,
   input  logic               bubble,
   input  logic [INSTR_W-1:0] instr_in,
   input  logic [PC_W-1:0]    pc_plus2_in,
   output logic [INSTR_W-1:0] instr,
   output logic [PC_W-1:0]    pc_plus2,
   output logic               valid
);

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         instr    <= NOP_INSTR;
         pc_plus2 <= '0;
         valid    <= 1'b0;
      end else if (hold) begin
         instr    <= instr;
         pc_plus2 <= pc_plus2;
         valid    <= valid;
      end else if (bubble) begin
         instr    <= NOP_INSTR;
         pc_plus2 <= '0;
         valid    <= 1'b0;
      end else begin
         instr    <= instr_in;
         pc_plus2 <= pc_plus2_in;
         valid    <= 1'b1;
      end
   end

endmodule

// File: rtl/instr_fetch_stage.sv
// Instruction-fetch stage: PC register, next-PC selection, BOOT/RUN/TRAP FSM and IF/ID register.
// Optional performance counters are built only when PERF_CNT_EN is defined.
//
// state | meaning
// BOOT  | first cycle after reset; IF/ID stays a bubble while RESET_PC is fetched
// RUN   | normal fetch: exception > stall > branch/flush > sequential
// TRAP  | one cycle after an exception; EXC_VECTOR word is fetched, new exceptions ignored
module instr_fetch_stage
   import cpu_defs::*;
#(
   parameter int              PC_W       = 16,
   parameter int              INSTR_W    = 16,
   parameter logic [PC_W-1:0] RESET_PC   = 16'h0000,
   parameter logic [PC_W-1:0] EXC_VECTOR = 16'h00F0,
   parameter logic [INSTR_W-1:0] NOP_INSTR = cpu_defs::NOP_INSTR
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               stall,
   input  logic               branch,
   input  logic [PC_W-1:0]    branchTarget,
   input  logic               IFIDFlush,
   input  logic               Exception,
   output logic [PC_W-1:0]    imem_addr,
   input  logic [INSTR_W-1:0] imem_rdata,
   output logic [INSTR_W-1:0] IFID_instr,
   output logic [PC_W-1:0]    IFID_pcPlus2,
   output logic               IFID_valid,
   output logic [3:0]         OPCode,
   output logic [3:0]         functionCode,
   output logic [PC_W-1:0]    EPC,
   output logic [15:0]        fetchCount,
   output logic [15:0]        flushCount
);

   fetch_state_e    state, state_next;
   logic [PC_W-1:0] pc, pc_next, pc_plus2;
   logic            ifid_hold, ifid_bubble, exc_take, redirect;

   assign pc_plus2  = pc + PC_W'(PC_INC);
   assign imem_addr = pc;

   always_comb begin
      state_next  = state;
      pc_next     = pc;
      ifid_hold   = 1'b0;
      ifid_bubble = 1'b0;
      exc_take    = 1'b0;
      redirect    = 1'b0;
      case (state)
         BOOT: begin
            ifid_bubble = 1'b1;
            state_next  = RUN;
         end
         RUN, TRAP: begin
            state_next = RUN;
            if (Exception && (state == RUN)) begin
               exc_take    = 1'b1;
               ifid_bubble = 1'b1;
               pc_next     = EXC_VECTOR;
               state_next  = TRAP;
            end else if (stall) begin
               ifid_hold = 1'b1;
            end else if (branch) begin
               ifid_bubble = 1'b1;
               redirect    = 1'b1;
               pc_next     = branchTarget;
            end else if (IFIDFlush) begin
               ifid_bubble = 1'b1;
               redirect    = 1'b1;
               pc_next     = pc_plus2;
            end else begin
               pc_next = pc_plus2;
            end
         end
         default: state_next = BOOT;
      endcase
   end

   // Instructions are halfword aligned, so bit 0 of the PC is never stored.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state <= BOOT;
         pc    <= {RESET_PC[PC_W-1:1], 1'b0};
         EPC   <= '0;
      end else begin
         state <= state_next;
         pc    <= {pc_next[PC_W-1:1], 1'b0};
         if (exc_take)
            EPC <= IFID_pcPlus2 - PC_W'(PC_INC);
      end
   end

   if_id_reg #(
      .INSTR_W   (INSTR_W),
      .PC_W      (PC_W),
      .NOP_INSTR (NOP_INSTR)
   ) u_if_id_reg (
      .clk         (clk),
      .rst_n       (rst_n),
      .hold        (ifid_hold),
      .bubble      (ifid_bubble),
      .instr_in    (imem_rdata),
      .pc_plus2_in (pc_plus2),
      .instr       (IFID_instr),
      .pc_plus2    (IFID_pcPlus2),
      .valid       (IFID_valid)
   );

   assign OPCode       = IFID_instr[OPCODE_MSB:OPCODE_LSB];
   assign functionCode = IFID_instr[FUNC_MSB:FUNC_LSB];

`ifdef PERF_CNT_EN
   logic fetch_inc, flush_inc;

   assign fetch_inc = !ifid_hold && !ifid_bubble;
   assign flush_inc = exc_take || redirect;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         fetchCount <= '0;
         flushCount <= '0;
      end else begin
         if (fetch_inc && (fetchCount != 16'hFFFF))
            fetchCount <= fetchCount + 16'd1;
         if (flush_inc && (flushCount != 16'hFFFF))
            flushCount <= flushCount + 16'd1;
      end
   end
`else
   assign fetchCount = 16'h0000;
   assign flushCount = 16'h0000;
`endif

endmodule
